// File: rtl/short_circuit_unit.sv
// short_circuit_unit: EX-stage forwarding selector for a 5-stage MIPS pipeline.
//
// Compares the rs/rt of the instruction in EX against the destination registers
// of the EX/MEM and MEM/WB instructions that will write back. It drives the ALU
// operand muxes combinationally and keeps two saturating event counters for debug.
//
// Ports:
//   i_clk            clock; the counters update on its rising edge
//   i_reset          asynchronous active-low reset (clears the counters only)
//   i_ex_mem_wb      EX/MEM instruction writes the register file
//   i_mem_wb_wb      MEM/WB instruction writes the register file
//   i_id_ex_rs       rs of the instruction in EX
//   i_id_ex_rt       rt of the instruction in EX
//   i_ex_mem_addr    destination register held in EX/MEM
//   i_mem_wb_addr    destination register held in MEM/WB
//   o_sc_data_a_src  operand-A select: 00 = ID/EX, 01 = MEM/WB, 10 = EX/MEM
//   o_sc_data_b_src  operand-B select, same encoding, driven from rt
//   o_fwd_ex_cnt     cycles in which either select was 10 (saturating)
//   o_fwd_wb_cnt     cycles in which either select was 01 (saturating)
module short_circuit_unit #(
  parameter int unsigned MEM_ADDR_SIZE = 5,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_ex_mem_wb,
  input  logic                     i_mem_wb_wb,
  input  logic [4:0]               i_id_ex_rs,
  input  logic [4:0]               i_id_ex_rt,
  input  logic [MEM_ADDR_SIZE-1:0] i_ex_mem_addr,
  input  logic [MEM_ADDR_SIZE-1:0] i_mem_wb_addr,
  output logic [1:0]               o_sc_data_a_src,
  output logic [1:0]               o_sc_data_b_src,
  output logic [CNT_WIDTH-1:0]     o_fwd_ex_cnt,
  output logic [CNT_WIDTH-1:0]     o_fwd_wb_cnt
);

  localparam int unsigned CmpW = (MEM_ADDR_SIZE > 5) ? MEM_ADDR_SIZE : 5;

  localparam logic [1:0] SrcIdEx  = 2'b00;
  localparam logic [1:0] SrcMemWb = 2'b01;
  localparam logic [1:0] SrcExMem = 2'b10;

  // Zero-extend everything to a common width so a wider destination address with
  // upper bits set can never alias onto a 5-bit register number.
  logic [CmpW-1:0] rs_ext, rt_ext, ex_mem_addr_ext, mem_wb_addr_ext;

  assign rs_ext          = CmpW'(i_id_ex_rs);
  assign rt_ext          = CmpW'(i_id_ex_rt);
  assign ex_mem_addr_ext = CmpW'(i_ex_mem_addr);
  assign mem_wb_addr_ext = CmpW'(i_mem_wb_addr);

  logic a_hit_ex, a_hit_wb, b_hit_ex, b_hit_wb;

  assign a_hit_ex = i_ex_mem_wb && (rs_ext == ex_mem_addr_ext);
  assign a_hit_wb = i_mem_wb_wb && (rs_ext == mem_wb_addr_ext);
  assign b_hit_ex = i_ex_mem_wb && (rt_ext == ex_mem_addr_ext);
  assign b_hit_wb = i_mem_wb_wb && (rt_ext == mem_wb_addr_ext);

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    o_sc_data_a_src = SrcIdEx;
    o_sc_data_b_src = SrcIdEx;
    if (a_hit_ex) begin
      o_sc_data_a_src = SrcExMem;
    end else if (a_hit_wb) begin
      o_sc_data_a_src = SrcMemWb;
    end
    if (b_hit_ex) begin
      o_sc_data_b_src = SrcExMem;
    end else if (b_hit_wb) begin
      o_sc_data_b_src = SrcMemWb;
    end
  end

  // Event counters: at most one increment per cycle, saturating at all-ones.
  logic                 any_ex, any_wb;
  logic [CNT_WIDTH-1:0] fwd_ex_cnt_d, fwd_ex_cnt_q;
  logic [CNT_WIDTH-1:0] fwd_wb_cnt_d, fwd_wb_cnt_q;

  assign any_ex = (o_sc_data_a_src == SrcExMem) || (o_sc_data_b_src == SrcExMem);
  assign any_wb = (o_sc_data_a_src == SrcMemWb) || (o_sc_data_b_src == SrcMemWb);

  always_comb begin
    fwd_ex_cnt_d = fwd_ex_cnt_q;
    fwd_wb_cnt_d = fwd_wb_cnt_q;
    if (any_ex && (fwd_ex_cnt_q != '1)) begin
      fwd_ex_cnt_d = fwd_ex_cnt_q + 1'b1;
    end
    if (any_wb && (fwd_wb_cnt_q != '1)) begin
      fwd_wb_cnt_d = fwd_wb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fwd_ex_cnt_q <= '0;
      fwd_wb_cnt_q <= '0;
    end else begin
      fwd_ex_cnt_q <= fwd_ex_cnt_d;
      fwd_wb_cnt_q <= fwd_wb_cnt_d;
    end
  end

  assign o_fwd_ex_cnt = fwd_ex_cnt_q;
  assign o_fwd_wb_cnt = fwd_wb_cnt_q;

endmodule

// File: tb/tb_short_circuit_unit.sv
// Bench for short_circuit_unit. Two instances share stimulus: u_dut0 uses the
// default parameters, u_dut1 has 6-bit destination addresses and 3-bit counters.
module tb_short_circuit_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_wb, wb_wb;
  logic [4:0] rs, rt;
  logic [5:0] ex_addr, wb_addr;

  logic [1:0]  a0, b0, a1, b1;
  logic [15:0] ex_cnt0, wb_cnt0;
  logic [2:0]  ex_cnt1, wb_cnt1;

  always #5 clk = ~clk;

  short_circuit_unit u_dut0 (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_ex_mem_wb     (ex_wb),
    .i_mem_wb_wb     (wb_wb),
    .i_id_ex_rs      (rs),
    .i_id_ex_rt      (rt),
    .i_ex_mem_addr   (ex_addr[4:0]),
    .i_mem_wb_addr   (wb_addr[4:0]),
    .o_sc_data_a_src (a0),
    .o_sc_data_b_src (b0),
    .o_fwd_ex_cnt    (ex_cnt0),
    .o_fwd_wb_cnt    (wb_cnt0)
  );

  short_circuit_unit #(
    .MEM_ADDR_SIZE (6),
    .CNT_WIDTH     (3)
  ) u_dut1 (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_ex_mem_wb     (ex_wb),
    .i_mem_wb_wb     (wb_wb),
    .i_id_ex_rs      (rs),
    .i_id_ex_rt      (rt),
    .i_ex_mem_addr   (ex_addr),
    .i_mem_wb_addr   (wb_addr),
    .o_sc_data_a_src (a1),
    .o_sc_data_b_src (b1),
    .o_fwd_ex_cnt    (ex_cnt1),
    .o_fwd_wb_cnt    (wb_cnt1)
  );

  typedef struct {
    string tag;
    int    a0, b0, a1, b1;
    int    ex0, wb0, ex1, wb1;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference counter state (value the counters should show right now).
  int m_ex0 = 0, m_wb0 = 0, m_ex1 = 0, m_wb1 = 0;

  // Forwarding source chosen from the priority rules: 2 = EX/MEM, 1 = MEM/WB, 0 = none.
  function automatic int ref_sel(bit ewb, bit wwb, int r, int ea, int wa);
    if (ewb && r == ea) return 2;
    if (wwb && r == wa) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(int v, bit hit, int maxv);
    if (!hit) return v;
    return (v + 1 > maxv) ? maxv : v + 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, push the expected
  // response, then advance the counter model for the next edge.
  task automatic apply(string tag, bit rst, bit ewb, bit wwb, logic [4:0] s, logic [4:0] t,
                       logic [5:0] ea, logic [5:0] wa);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; ex_wb = ewb; wb_wb = wwb; rs = s; rt = t; ex_addr = ea; wb_addr = wa;
    if (!rst) begin
      m_ex0 = 0; m_wb0 = 0; m_ex1 = 0; m_wb1 = 0;
    end
    e.tag = tag;
    e.a0  = ref_sel(ewb, wwb, int'(s), int'(ea[4:0]), int'(wa[4:0]));
    e.b0  = ref_sel(ewb, wwb, int'(t), int'(ea[4:0]), int'(wa[4:0]));
    e.a1  = ref_sel(ewb, wwb, int'(s), int'(ea), int'(wa));
    e.b1  = ref_sel(ewb, wwb, int'(t), int'(ea), int'(wa));
    e.ex0 = m_ex0; e.wb0 = m_wb0; e.ex1 = m_ex1; e.wb1 = m_wb1;
    sb.push_back(e);
    if (rst) begin
      m_ex0 = sat_inc(m_ex0, (e.a0 == 2) || (e.b0 == 2), 65535);
      m_wb0 = sat_inc(m_wb0, (e.a0 == 1) || (e.b0 == 1), 65535);
      m_ex1 = sat_inc(m_ex1, (e.a1 == 2) || (e.b1 == 2), 7);
      m_wb1 = sat_inc(m_wb1, (e.a1 == 1) || (e.b1 == 1), 7);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".a0"},  int'(a0),      e.a0);
      chk({e.tag, ".b0"},  int'(b0),      e.b0);
      chk({e.tag, ".a1"},  int'(a1),      e.a1);
      chk({e.tag, ".b1"},  int'(b1),      e.b1);
      chk({e.tag, ".ex0"}, int'(ex_cnt0), e.ex0);
      chk({e.tag, ".wb0"}, int'(wb_cnt0), e.wb0);
      chk({e.tag, ".ex1"}, int'(ex_cnt1), e.ex1);
      chk({e.tag, ".wb1"}, int'(wb_cnt1), e.wb1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s, t;
    logic [5:0] ea, wa;
    int         waited;
    void'($urandom(32'd1234));
    rst_n = 1'b0; ex_wb = 1'b0; wb_wb = 1'b0;
    rs = '0; rt = '0; ex_addr = '0; wb_addr = '0;
    repeat (2) @(posedge clk);

    apply("reset",     1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  6'd0,  6'd0);
    apply("idle",      1'b1, 1'b0, 1'b0, 5'd1,  5'd2,  6'd3,  6'd4);
    apply("a_exmem",   1'b1, 1'b1, 1'b0, 5'd13, 5'd0,  6'd13, 6'd0);
    apply("b_memwb",   1'b1, 1'b0, 1'b1, 5'd0,  5'd7,  6'd0,  6'd7);
    apply("a_ex_off",  1'b1, 1'b0, 1'b0, 5'd13, 5'd0,  6'd13, 6'd0);
    apply("b_wb_off",  1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  6'd0,  6'd7);
    apply("prio",      1'b1, 1'b1, 1'b1, 5'd4,  5'd4,  6'd4,  6'd4);
    apply("split",     1'b1, 1'b1, 1'b1, 5'd9,  5'd21, 6'd9,  6'd21);
    apply("zext_hi",   1'b1, 1'b1, 1'b1, 5'd5,  5'd6,  6'd37, 6'd38);

    // Hold EX/MEM forwarding for five edges, then observe the count.
    apply("clr",       1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  6'd0,  6'd0);
    for (int i = 0; i < 5; i++) apply("hold5", 1'b1, 1'b1, 1'b0, 5'd13, 5'd1, 6'd13, 6'd2);
    apply("cnt5",      1'b1, 1'b0, 1'b0, 5'd13, 5'd1, 6'd13, 6'd2);
    apply("rst_mid",   1'b0, 1'b1, 1'b0, 5'd13, 5'd1, 6'd13, 6'd2);

    // Ten forwarding edges: 3-bit counter must pin at 7.
    for (int i = 0; i < 10; i++) apply("sat", 1'b1, 1'b1, 1'b1, 5'd3, 5'd8, 6'd3, 6'd8);
    apply("sat_end",   1'b1, 1'b0, 1'b0, 5'd3, 5'd8, 6'd3, 6'd8);

    for (int i = 0; i < 100; i++) begin
      s  = 5'($urandom_range(0, 31));
      t  = ($urandom_range(0, 3) == 0) ? s : 5'($urandom_range(0, 31));
      ea = ($urandom_range(0, 2) == 0) ? {1'b0, s} : 6'($urandom_range(0, 63));
      wa = ($urandom_range(0, 2) == 0) ? {1'b0, t} : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) ea[5] = 1'b1;
      if ($urandom_range(0, 3) == 0) wa[5] = 1'b1;
      apply("rand", ($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom), s, t, ea, wa);
    end
    apply("final", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 6'd0, 6'd0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
